// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor. Operands are captured on a start
//               strobe and summed LSB-first through one shared full-adder
//               cell, one bit per clock. Result, carry/borrow and signed
//               overflow are registered and presented with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  // Counter is one bit wider than clog2 so WIDTH=1 still has a real register.
  localparam int            CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH:0]   w_res_cat;
  logic [WIDTH-1:0] w_res_next;

  // Shared full-adder cell operating on the current LSBs and running carry.
  always_comb begin
    w_s        = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    w_c        = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    w_last     = (cnt_q == C_LAST);
    // New bit enters at the MSB end; after WIDTH shifts bit 0 is the LSB.
    w_res_cat  = {w_s, res_q};
    w_res_next = w_res_cat[WIDTH:1];
  end

  // Next-state logic: capture in IDLE, one full-adder step per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = w_res_next;
        carry_d = w_c;
        cnt_d   = cnt_q + C_ONE;
        if (w_last) begin
          // On the MSB step carry_q is the carry into the sign bit.
          sum_d   = {w_c, w_res_next};
          ovf_d   = carry_q ^ w_c;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder at WIDTH 4, 1, 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, ovf4;
  logic [4:0] sum4;

  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, ovf1;
  logic [1:0] sum1;

  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, ovf8;
  logic [8:0] sum8;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy4, done4, sum4, ovf4} !== 8'd0) begin
      n_fail++; $display("FAIL reset_w4: got busy=%b done=%b sum=%b ovf=%b, want all 0", busy4, done4, sum4, ovf4);
    end
    n_checks++;
    if ({busy1, done1, sum1, ovf1} !== 5'd0) begin
      n_fail++; $display("FAIL reset_w1: got busy=%b done=%b sum=%b ovf=%b, want all 0", busy1, done1, sum1, ovf1);
    end
    n_checks++;
    if ({busy8, done8, sum8, ovf8} !== 12'd0) begin
      n_fail++; $display("FAIL reset_w8: got busy=%b done=%b sum=%b ovf=%b, want all 0", busy8, done8, sum8, ovf8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One WIDTH=4 operation: checks busy, latency, result, overflow, done width.
  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                      input logic [4:0] exp_sum, input logic exp_ovf, input string name);
    int n;
    start4 = 1'b1; a4 = ta; b4 = tb; sub4 = ts;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~ta; b4 = ~tb; sub4 = ~ts;
    n_checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got busy=%b done=%b, want busy=1 done=0", name, busy4, done4);
    end
    n = 1;
    while (done4 !== 1'b1 && n < 20) begin
      n_checks++;
      if (busy4 !== 1'b1) begin
        n_fail++; $display("FAIL %s_busy_hold: got busy=%b at cycle %0d, want 1", name, busy4, n);
      end
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 5) begin
      n_fail++; $display("FAIL %s_latency: got done after %0d edges, want 4", name, n - 1);
    end
    n_checks++;
    if (sum4 !== exp_sum || ovf4 !== exp_ovf || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL %s_result: got sum=%b ovf=%b busy=%b, want sum=%b ovf=%b busy=0",
                         name, sum4, ovf4, busy4, exp_sum, exp_ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done4 !== 1'b0 || sum4 !== exp_sum) begin
      n_fail++; $display("FAIL %s_hold: got done=%b sum=%b, want done=0 sum=%b", name, done4, sum4, exp_sum);
    end
  endtask

  task automatic test_add();
    run4(4'd3,  4'd2,  1'b0, 5'b00101, 1'b0, "add_3_2");
    run4(4'd15, 4'd15, 1'b0, 5'b11110, 1'b0, "add_15_15");
    run4(4'd7,  4'd1,  1'b0, 5'b01000, 1'b1, "add_7_1");
  endtask

  task automatic test_sub();
    run4(4'd5, 4'd7, 1'b1, 5'b01110, 1'b0, "sub_5_7");
    run4(4'd8, 4'd1, 1'b1, 5'b10111, 1'b1, "sub_8_1");
  endtask

  task automatic test_back_to_back();
    int n;
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd2; sub4 = 1'b0;
    @(posedge clk); #1;                 // edge k
    start4 = 1'b0;
    @(posedge clk); #1;                 // k+1
    @(posedge clk); #1;                 // k+2: re-pulse, must be ignored
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(posedge clk); #1;                 // k+3
    start4 = 1'b0;
    @(posedge clk); #1;                 // k+4
    n_checks++;
    if (done4 !== 1'b1 || sum4 !== 5'd5) begin
      n_fail++; $display("FAIL ignore_start: got done=%b sum=%0d, want done=1 sum=5", done4, sum4);
    end
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; sub4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    n_checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b1 || sum4 !== 5'd5) begin
      n_fail++; $display("FAIL b2b_accept: got done=%b busy=%b sum=%0d, want done=0 busy=1 sum=5", done4, busy4, sum4);
    end
    n = 1;
    while (done4 !== 1'b1 && n < 20) begin
      n_checks++;
      if (sum4 !== 5'd5) begin
        n_fail++; $display("FAIL b2b_sum_hold: got sum=%0d, want 5", sum4);
      end
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 5 || sum4 !== 5'd2 || ovf4 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_result: got edges=%0d sum=%0d ovf=%b, want edges=4 sum=2 ovf=0", n - 1, sum4, ovf4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int n;
    run4(4'd7, 4'd1, 1'b0, 5'b01000, 1'b1, "pre_rst");
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd2; sub4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #3 rst = 1'b1;                      // mid-cycle, no clock edge involved
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 5'd0 || ovf4 !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: got busy=%b done=%b sum=%b ovf=%b, want all 0", busy4, done4, sum4, ovf4);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) n++;
    end
    n_checks++;
    if (n !== 0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_done: got %0d done pulses busy=%b, want 0 and busy=0", n, busy4);
    end
    run4(4'd3, 4'd2, 1'b0, 5'b00101, 1'b0, "post_rst");
  endtask

  task automatic test_width1();
    int n;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 1;
    while (done1 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 2 || sum1 !== 2'b10 || ovf1 !== 1'b1) begin
      n_fail++; $display("FAIL w1_add: got edges=%0d sum=%b ovf=%b, want edges=1 sum=10 ovf=1", n - 1, sum1, ovf1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_done_pulse: got done=%b, want 0", done1);
    end
  endtask

  task automatic test_width8();
    int n;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 9 || sum8 !== 9'd300 || ovf8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_add: got edges=%0d sum=%0d ovf=%b, want edges=8 sum=300 ovf=0", n - 1, sum8, ovf8);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_async_reset();
    test_width1();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
